// File: rtl/btb_sa.sv
// Set-associative branch target buffer: tree pseudo-LRU replacement, combinational lookup.
// Define BTB_SA_COUNTER_EN to add 2-bit saturating direction counters per entry.
module btb_sa #(
    parameter int WIDTH = 16,
    parameter int SETS  = 8,
    parameter int WAYS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lookup_en,
    input  logic [WIDTH-1:0] lookup_pc,
    output logic             hit,
    output logic             predict_taken,
    output logic [WIDTH-1:0] target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target
);
    localparam int IDX_W = $clog2(SETS);
    localparam int LVL   = $clog2(WAYS);
    localparam int TAG_W = WIDTH - IDX_W - 1;
    localparam int NODES = WAYS - 1;

    logic [WAYS-1:0]  valid_reg  [SETS];
    logic [TAG_W-1:0] tag_reg    [SETS][WAYS];
    logic [WIDTH-1:0] target_reg [SETS][WAYS];
    logic [NODES-1:0] plru_reg   [SETS];
`ifdef BTB_SA_COUNTER_EN
    logic [1:0]       ctr_reg    [SETS][WAYS];
`endif

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    function automatic logic [LVL-1:0] plru_victim(input logic [NODES-1:0] bits);
        int node;
        node = 0;
        for (int l = 0; l < LVL; l++)
            node = bits[node] ? 2 * node + 2 : 2 * node + 1;
        return LVL'(node - NODES);
    endfunction

    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [LVL-1:0]   way);
        logic [NODES-1:0] r;
        int node;
        r    = bits;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            r[node] = ~way[LVL-1-l];
            node    = way[LVL-1-l] ? 2 * node + 2 : 2 * node + 1;
        end
        return r;
    endfunction

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic [WAYS-1:0]  lk_match, upd_match;
    logic [LVL-1:0]   lk_way, upd_way, inv_way, alloc_way, touch_way;
    logic             lk_any, upd_any, upd_hit, alloc, upd_touch, lk_touch;
    logic             unused_bits;

    assign lk_idx      = lookup_pc[IDX_W:1];
    assign lk_tag      = lookup_pc[WIDTH-1:IDX_W+1];
    assign upd_idx     = upd_pc[IDX_W:1];
    assign upd_tag     = upd_pc[WIDTH-1:IDX_W+1];
    assign unused_bits = &{1'b0, lookup_pc[0], upd_pc[0]};

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign lk_match[gi]  = valid_reg[lk_idx][gi]  && (tag_reg[lk_idx][gi]  == lk_tag);
        assign upd_match[gi] = valid_reg[upd_idx][gi] && (tag_reg[upd_idx][gi] == upd_tag);
    end

    // Descending scans so the lowest-numbered candidate is the one that sticks.
    always_comb begin
        lk_way  = '0;
        lk_any  = 1'b0;
        upd_way = '0;
        upd_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                lk_any = 1'b1;
                lk_way = LVL'(w);
            end
            if (upd_match[w]) begin
                upd_any = 1'b1;
                upd_way = LVL'(w);
            end
            if (!valid_reg[upd_idx][w])
                inv_way = LVL'(w);
        end
    end

    assign hit    = lookup_en & lk_any;
    assign target = hit ? target_reg[lk_idx][lk_way] : '0;
`ifdef BTB_SA_COUNTER_EN
    assign predict_taken = hit & ctr_reg[lk_idx][lk_way][1];
`else
    assign predict_taken = hit;
`endif

    assign upd_hit   = upd_valid & upd_any;
    assign alloc     = upd_valid & ~upd_any & upd_taken;
    assign alloc_way = (&valid_reg[upd_idx]) ? plru_victim(plru_reg[upd_idx]) : inv_way;
`ifdef BTB_SA_COUNTER_EN
    assign upd_touch = upd_hit | alloc;
`else
    assign upd_touch = (upd_hit & upd_taken) | alloc;
`endif
    assign touch_way = upd_hit ? upd_way : alloc_way;
    // Update touch wins when both land in the same set.
    assign lk_touch  = hit & ~(upd_touch & (upd_idx == lk_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                plru_reg[s]  <= '0;
`ifdef BTB_SA_COUNTER_EN
                for (int w = 0; w < WAYS; w++)
                    ctr_reg[s][w] <= 2'b00;
`endif
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++)
                valid_reg[s] <= '0;
        end else begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_reg[upd_idx][upd_way] <= upd_target;
`ifdef BTB_SA_COUNTER_EN
                    if (ctr_reg[upd_idx][upd_way] != 2'b11)
                        ctr_reg[upd_idx][upd_way] <= ctr_reg[upd_idx][upd_way] + 2'd1;
`endif
                end else begin
`ifdef BTB_SA_COUNTER_EN
                    if (ctr_reg[upd_idx][upd_way] != 2'b00)
                        ctr_reg[upd_idx][upd_way] <= ctr_reg[upd_idx][upd_way] - 2'd1;
`else
                    valid_reg[upd_idx][upd_way] <= 1'b0;
`endif
                end
            end
            if (alloc) begin
                valid_reg[upd_idx][alloc_way]  <= 1'b1;
                tag_reg[upd_idx][alloc_way]    <= upd_tag;
                target_reg[upd_idx][alloc_way] <= upd_target;
`ifdef BTB_SA_COUNTER_EN
                ctr_reg[upd_idx][alloc_way]    <= 2'b10;
`endif
            end
            if (upd_touch)
                plru_reg[upd_idx] <= plru_touch(plru_reg[upd_idx], touch_way);
            if (lk_touch)
                plru_reg[lk_idx] <= plru_touch(plru_reg[lk_idx], lk_way);
        end
    end
endmodule

// File: tb/tb_btb_sa.sv
// Directed bench for btb_sa (WIDTH=16, SETS=8, WAYS=4); expectations follow BTB_SA_COUNTER_EN.
module tb_btb_sa;
`ifdef BTB_SA_COUNTER_EN
    localparam bit CTR = 1'b1;
`else
    localparam bit CTR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        lookup_en = 1'b0;
    logic [15:0] lookup_pc = '0;
    logic        hit, predict_taken;
    logic [15:0] target;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    int          total = 0;
    int          bad = 0;

    btb_sa #(.WIDTH(16), .SETS(8), .WAYS(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .hit(hit), .predict_taken(predict_taken), .target(target),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%04h expected=%04h", name, got, want);
        end
    endtask

    // Lookups happen mid-cycle and are released before the next edge, so they never touch PLRU.
    task automatic look(input string name, input logic [15:0] pc, input logic en,
                        input logic eh, input logic ep, input logic [15:0] et);
        @(negedge clk);
        lookup_en = en;
        lookup_pc = pc;
        #1;
        cmp({name, ".hit"}, {15'd0, hit}, {15'd0, eh});
        cmp({name, ".pt"}, {15'd0, predict_taken}, {15'd0, ep});
        cmp({name, ".tgt"}, target, et);
        $display("look %s pc=%04h hit=%0b pt=%0b tgt=%04h", name, pc, hit, predict_taken, target);
        lookup_en = 1'b0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        $display("upd pc=%04h taken=%0b target=%04h", pc, tk, tg);
    endtask

    task automatic touch(input logic [15:0] pc);
        @(negedge clk);
        lookup_en = 1'b1;
        lookup_pc = pc;
        @(posedge clk);
        #1;
        lookup_en = 1'b0;
        $display("touch pc=%04h", pc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        look("rst", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Allocate and read back
        upd(16'h3000, 1'b1, 16'h3040);
        look("alloc", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h3040);
        look("en_off", 16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Counter decrement / invalidate without counters
        upd(16'h3000, 1'b0, 16'h0000);
        look("nt1", 16'h3000, 1'b1, CTR, 1'b0, CTR ? 16'h3040 : 16'h0000);
        upd(16'h3000, 1'b0, 16'h0000);
        look("nt2", 16'h3000, 1'b1, CTR, 1'b0, CTR ? 16'h3040 : 16'h0000);
        upd(16'h3000, 1'b0, 16'h0000);
        upd(16'h3000, 1'b1, 16'h3044);
        look("no_uflow", 16'h3000, 1'b1, 1'b1, !CTR, 16'h3044);
        upd(16'h3000, 1'b1, 16'h3048);
        upd(16'h3000, 1'b1, 16'h3048);
        upd(16'h3000, 1'b1, 16'h3048);
        upd(16'h3000, 1'b0, 16'h0000);
        look("sat_hi", 16'h3000, 1'b1, CTR, CTR, CTR ? 16'h3048 : 16'h0000);

        // Eviction in set 0
        do_reset();
        upd(16'h3000, 1'b1, 16'h0100);
        upd(16'h3010, 1'b1, 16'h0110);
        upd(16'h3020, 1'b1, 16'h0120);
        upd(16'h3030, 1'b1, 16'h0130);
        touch(16'h3000);
        upd(16'h3040, 1'b1, 16'h0140);
        look("ev_3020", 16'h3020, 1'b1, 1'b0, 1'b0, 16'h0000);
        look("ev_3000", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h0100);
        look("ev_3010", 16'h3010, 1'b1, 1'b1, 1'b1, 16'h0110);
        look("ev_3030", 16'h3030, 1'b1, 1'b1, 1'b1, 16'h0130);
        look("ev_3040", 16'h3040, 1'b1, 1'b1, 1'b1, 16'h0140);

        // Not-taken miss leaves the set alone; next victim is way 1
        upd(16'h5000, 1'b0, 16'h0500);
        look("nt_miss", 16'h5000, 1'b1, 1'b0, 1'b0, 16'h0000);
        upd(16'h3050, 1'b1, 16'h0150);
        look("ev2_3010", 16'h3010, 1'b1, 1'b0, 1'b0, 16'h0000);
        look("ev2_3050", 16'h3050, 1'b1, 1'b1, 1'b1, 16'h0150);
        look("ev2_3000", 16'h3000, 1'b1, 1'b1, 1'b1, 16'h0100);

        // Flush drops the same-cycle update
        @(negedge clk);
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 16'h6000;
        upd_taken  = 1'b1;
        upd_target = 16'h0600;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        upd_valid = 1'b0;
        $display("flush with upd pc=6000");
        look("fl_6000", 16'h6000, 1'b1, 1'b0, 1'b0, 16'h0000);
        look("fl_3000", 16'h3000, 1'b1, 1'b0, 1'b0, 16'h0000);
        look("fl_3040", 16'h3040, 1'b1, 1'b0, 1'b0, 16'h0000);

        // No bypass: same-cycle lookup sees pre-update contents
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 16'h7000;
        upd_taken  = 1'b1;
        upd_target = 16'h0700;
        lookup_en  = 1'b1;
        lookup_pc  = 16'h7000;
        #1;
        cmp("bypass.hit", {15'd0, hit}, 16'h0000);
        $display("look bypass pc=7000 hit=%0b", hit);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        lookup_en = 1'b0;
        look("post_upd", 16'h7000, 1'b1, 1'b1, 1'b1, 16'h0700);

        // Reset together with an update
        @(negedge clk);
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 16'h7010;
        upd_taken  = 1'b1;
        upd_target = 16'h0710;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        $display("rst with upd pc=7010");
        look("rs_7010", 16'h7010, 1'b1, 1'b0, 1'b0, 16'h0000);
        look("rs_7000", 16'h7000, 1'b1, 1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
